// File: rtl/cpu_defs.sv
// Shared types and constants for the memory-bus arbiter and its cache-side clients.
package cpu_defs;

  localparam int LEN_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_RDATA = 3'd2,
    ST_WDATA = 3'd3,
    ST_WRESP = 3'd4
  } mem_arb_state_t;

  typedef struct packed {
    logic                 we;
    logic [31:0]          addr;
    logic [LEN_WIDTH-1:0] len;
  } mem_burst_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant pick: fixed-priority master first, then round-robin from rr_ptr.
module rr_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int PRIO_MASTER = 2,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_valid
);

  logic [IDX_W-1:0] rr_idx;
  logic             rr_valid;

  always_comb begin
    int k;
    k        = 0;
    rr_idx   = '0;
    rr_valid = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      // Scan upward from rr_ptr, wrapping at NUM_MASTERS rather than a power of two.
      k = int'(rr_ptr) + i;
      if (k >= NUM_MASTERS) k = k - NUM_MASTERS;
      if (!rr_valid && req[k]) begin
        rr_valid = 1'b1;
        rr_idx   = IDX_W'(k);
      end
    end
  end

  generate
    if (PRIO_MASTER < NUM_MASTERS) begin : g_prio
      assign grant_idx = req[PRIO_MASTER] ? IDX_W'(PRIO_MASTER) : rr_idx;
    end else begin : g_no_prio
      assign grant_idx = rr_idx;
    end
  endgenerate

  assign grant_valid = rr_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
      assign grant[gi] = grant_valid && (grant_idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one burst memory port among the I$, D$ and uncached masters:
// arbitration, address/data/response sequencing and beat counting.
module mem_bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int PRIO_MASTER = 2,
  parameter int LEN_WIDTH   = cpu_defs::LEN_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_MASTERS-1:0]           m_req,
  input  logic [NUM_MASTERS-1:0]           m_we,
  input  logic [NUM_MASTERS*32-1:0]        m_addr,
  input  logic [NUM_MASTERS*LEN_WIDTH-1:0] m_len,
  output logic [NUM_MASTERS-1:0]           m_ack,
  input  logic [NUM_MASTERS*32-1:0]        m_wdata,
  input  logic [NUM_MASTERS-1:0]           m_wvalid,
  output logic [NUM_MASTERS-1:0]           m_wready,
  output logic [31:0]                      m_rdata,
  output logic [NUM_MASTERS-1:0]           m_rvalid,
  output logic                             m_rlast,
  output logic [NUM_MASTERS-1:0]           m_done,
  output logic                             s_req,
  output logic                             s_we,
  output logic [31:0]                      s_addr,
  output logic [LEN_WIDTH-1:0]             s_len,
  input  logic                             s_ack,
  output logic [31:0]                      s_wdata,
  output logic                             s_wvalid,
  output logic                             s_wlast,
  input  logic                             s_wready,
  input  logic [31:0]                      s_rdata,
  input  logic                             s_rvalid,
  input  logic                             s_rlast,
  input  logic                             s_bvalid,
  output logic                             proto_err
);
  import cpu_defs::*;

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  mem_arb_state_t       state_reg;
  logic [IDX_W-1:0]     rr_ptr_reg;
  logic [IDX_W-1:0]     grant_reg;
  mem_burst_req_t       burst_reg;
  logic [LEN_WIDTH-1:0] beat_cnt_reg;
  logic                 proto_err_reg;

  mem_burst_req_t       mreq [NUM_MASTERS];
  logic [31:0]          wdata_arr [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] grant_oh;
  logic [NUM_MASTERS-1:0] arb_oh;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic [IDX_W-1:0]     ptr_next;
  logic [LEN_WIDTH-1:0] burst_len;
  logic                 in_addr, in_rd, in_wr, in_wresp;
  logic                 w_fire, last_beat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      // Burst descriptor length follows cpu_defs::LEN_WIDTH; the cast keeps widths explicit.
      assign mreq[gi].we   = m_we[gi];
      assign mreq[gi].addr = m_addr[gi*32 +: 32];
      assign mreq[gi].len  = $bits(mreq[gi].len)'(m_len[gi*LEN_WIDTH +: LEN_WIDTH]);
      assign wdata_arr[gi] = m_wdata[gi*32 +: 32];
      assign grant_oh[gi]  = (grant_reg == IDX_W'(gi));
    end
  endgenerate

  rr_arbiter #(
    .NUM_MASTERS(NUM_MASTERS),
    .PRIO_MASTER(PRIO_MASTER),
    .IDX_W      (IDX_W)
  ) u_rr_arbiter (
    .req        (m_req),
    .rr_ptr     (rr_ptr_reg),
    .grant      (arb_oh),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  assign in_addr   = (state_reg == ST_ADDR);
  assign in_rd     = (state_reg == ST_RDATA);
  assign in_wr     = (state_reg == ST_WDATA);
  assign in_wresp  = (state_reg == ST_WRESP);
  assign burst_len = LEN_WIDTH'(burst_reg.len);
  assign last_beat = (beat_cnt_reg == burst_len);
  assign ptr_next  = (grant_reg == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_reg + 1'b1;

  // Slave side is driven only from the latched descriptor, never from live master inputs.
  assign s_req     = in_addr;
  assign s_we      = in_addr & burst_reg.we;
  assign s_addr    = in_addr ? burst_reg.addr : '0;
  assign s_len     = in_addr ? burst_len : '0;
  assign s_wdata   = in_wr ? wdata_arr[grant_reg] : '0;
  assign s_wvalid  = in_wr & m_wvalid[grant_reg];
  assign s_wlast   = in_wr & last_beat;
  assign w_fire    = s_wvalid & s_wready;

  assign m_ack     = (in_addr && s_ack) ? grant_oh : '0;
  assign m_wready  = (in_wr && s_wready) ? grant_oh : '0;
  assign m_rdata   = in_rd ? s_rdata : '0;
  assign m_rvalid  = (in_rd && s_rvalid) ? grant_oh : '0;
  assign m_rlast   = in_rd & s_rvalid & s_rlast;
  assign m_done    = ((in_rd && s_rvalid && s_rlast) || (in_wresp && s_bvalid)) ? grant_oh : '0;
  assign proto_err = proto_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      burst_reg     <= '0;
      beat_cnt_reg  <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_reg <= arb_idx;
            burst_reg <= mreq[arb_idx];
            state_reg <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (s_ack) begin
            beat_cnt_reg <= '0;
            state_reg    <= burst_reg.we ? ST_WDATA : ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (s_rvalid) begin
            // s_rlast ends the burst regardless of the count; mismatches only flag.
            if (s_rlast) begin
              if (!last_beat) proto_err_reg <= 1'b1;
              rr_ptr_reg <= ptr_next;
              state_reg  <= ST_IDLE;
            end else if (last_beat) begin
              proto_err_reg <= 1'b1;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
        ST_WDATA: begin
          if (s_bvalid) proto_err_reg <= 1'b1;
          if (w_fire) begin
            if (last_beat) state_reg <= ST_WRESP;
            else           beat_cnt_reg <= beat_cnt_reg + 1'b1;
          end
        end
        ST_WRESP: begin
          if (s_bvalid) begin
            rr_ptr_reg <= ptr_next;
            state_reg  <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: reads, writes, arbitration, errors, reset.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_req, m_we, m_wvalid;
  logic [95:0] m_addr, m_wdata;
  logic [11:0] m_len;
  logic [2:0]  m_ack, m_wready, m_rvalid, m_done;
  logic [31:0] m_rdata;
  logic        m_rlast;
  logic        s_req, s_we, s_ack, s_wvalid, s_wlast, s_wready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_len;
  logic        s_rvalid, s_rlast, s_bvalid, proto_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_len(m_len), .m_ack(m_ack),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_done(m_done),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_len(s_len), .s_ack(s_ack),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_bvalid(s_bvalid),
    .proto_err(proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int m, input logic we, input logic [31:0] addr, input logic [3:0] len);
    m_we[m]          = we;
    m_addr[m*32 +: 32] = addr;
    m_len[m*4 +: 4]  = len;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for the address phase, checks address, acks and checks m_ack.
  task automatic addr_phase(input string name, input logic [31:0] exp_addr, input logic [2:0] exp_ack);
    int n;
    n = 0;
    while (!s_req && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (s_req !== 1'b1) begin
      errors++;
      $display("FAIL %s_s_req: got %b expected 1 (timeout)", name, s_req);
    end
    checks++;
    if (s_addr !== exp_addr) begin
      errors++;
      $display("FAIL %s_s_addr: got %h expected %h", name, s_addr, exp_addr);
    end
    s_ack = 1'b1;
    #1;
    checks++;
    if (m_ack !== exp_ack) begin
      errors++;
      $display("FAIL %s_m_ack: got %b expected %b", name, m_ack, exp_ack);
    end
    $display("txn %s: addr=%h ack=%b", name, s_addr, m_ack);
    tick();
    s_ack = 1'b0;
  endtask

  // Delivers nbeats read beats, s_rlast on the final one.
  task automatic read_burst(input string name, input int m, input int nbeats);
    logic [2:0]  exp_oh;
    logic [31:0] d;
    exp_oh = 3'b001 << m;
    for (int b = 0; b < nbeats; b++) begin
      d = 32'hD000_0000 + 32'(b) + (32'(m) << 8);
      s_rvalid = 1'b1;
      s_rdata  = d;
      s_rlast  = (b == nbeats - 1);
      #1;
      checks++;
      if (m_rvalid !== exp_oh || m_rdata !== d) begin
        errors++;
        $display("FAIL %s_beat%0d: got rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                 name, b, m_rvalid, m_rdata, exp_oh, d);
      end
      checks++;
      if (m_done !== ((b == nbeats - 1) ? exp_oh : 3'b000) || m_rlast !== (b == nbeats - 1)) begin
        errors++;
        $display("FAIL %s_done%0d: got done=%b rlast=%b expected done=%b rlast=%b",
                 name, b, m_done, m_rlast, ((b == nbeats - 1) ? exp_oh : 3'b000), (b == nbeats - 1));
      end
      $display("txn %s beat %0d: rvalid=%b rdata=%h done=%b", name, b, m_rvalid, m_rdata, m_done);
      tick();
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({s_req, s_we, s_wvalid, s_wlast, m_rlast, proto_err} !== 6'b0 ||
        m_ack !== 3'b0 || m_done !== 3'b0 || m_rvalid !== 3'b0 || s_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got s_req=%b ack=%b done=%b rvalid=%b s_addr=%h err=%b expected all 0",
               s_req, m_ack, m_done, m_rvalid, s_addr, proto_err);
    end
    $display("txn reset: s_req=%b proto_err=%b", s_req, proto_err);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    set_master(0, 1'b0, 32'h1FC0_0000, 4'd3);
    m_req = 3'b001;
    tick();
    checks++;
    if (s_req !== 1'b1 || s_we !== 1'b0 || s_len !== 4'd3 || m_ack !== 3'b000) begin
      errors++;
      $display("FAIL single_addr_phase: got s_req=%b we=%b len=%0d ack=%b expected 1 0 3 000",
               s_req, s_we, s_len, m_ack);
    end
    addr_phase("single", 32'h1FC0_0000, 3'b001);
    m_req = 3'b000;
    read_burst("single", 0, 4);
    s_rvalid = 1'b1;
    #1;
    checks++;
    if (s_req !== 1'b0 || m_rvalid !== 3'b000 || m_done !== 3'b000) begin
      errors++;
      $display("FAIL single_idle: got s_req=%b rvalid=%b done=%b expected 0 000 000", s_req, m_rvalid, m_done);
    end
    s_rvalid = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [31:0] a [2];
    a[0] = 32'h0000_1000;
    a[1] = 32'h0000_2000;
    pulse_reset();
    set_master(0, 1'b0, a[0], 4'd0);
    set_master(1, 1'b0, a[1], 4'd0);
    m_req = 3'b011;
    for (int i = 0; i < 4; i++) begin
      addr_phase($sformatf("rr%0d", i), a[i % 2], 3'b001 << (i % 2));
      read_burst($sformatf("rr%0d", i), i % 2, 1);
    end
    m_req = 3'b000;
  endtask

  task automatic test_priority_write();
    pulse_reset();
    set_master(0, 1'b0, 32'h0000_3000, 4'd0);
    set_master(2, 1'b1, 32'h1F00_0010, 4'd1);
    m_req = 3'b101;
    tick();
    checks++;
    if (s_we !== 1'b1 || s_len !== 4'd1) begin
      errors++;
      $display("FAIL prio_desc: got we=%b len=%0d expected 1 1", s_we, s_len);
    end
    addr_phase("prio", 32'h1F00_0010, 3'b100);
    m_req = 3'b001;
    m_wvalid = 3'b100;
    m_wdata[64 +: 32] = 32'hCAFE_0000;
    s_wready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (s_wvalid !== 1'b1 || s_wdata !== 32'hCAFE_0000 || s_wlast !== 1'b0 || m_wready !== 3'b000) begin
        errors++;
        $display("FAIL wr_stall%0d: got wvalid=%b wdata=%h wlast=%b wready=%b expected 1 cafe0000 0 000",
                 i, s_wvalid, s_wdata, s_wlast, m_wready);
      end
      $display("txn wr stall %0d: wready=%b", i, m_wready);
      tick();
    end
    s_wready = 1'b1;
    #1;
    checks++;
    if (m_wready !== 3'b100 || s_wlast !== 1'b0) begin
      errors++;
      $display("FAIL wr_beat0: got wready=%b wlast=%b expected 100 0", m_wready, s_wlast);
    end
    tick();
    m_wdata[64 +: 32] = 32'hCAFE_0001;
    #1;
    checks++;
    if (s_wdata !== 32'hCAFE_0001 || s_wlast !== 1'b1 || m_wready !== 3'b100) begin
      errors++;
      $display("FAIL wr_beat1: got wdata=%h wlast=%b wready=%b expected cafe0001 1 100", s_wdata, s_wlast, m_wready);
    end
    tick();
    m_wvalid = 3'b000;
    s_wready = 1'b0;
    #1;
    checks++;
    if (m_done !== 3'b000 || s_wvalid !== 1'b0) begin
      errors++;
      $display("FAIL wresp_wait: got done=%b wvalid=%b expected 000 0", m_done, s_wvalid);
    end
    tick();
    s_bvalid = 1'b1;
    #1;
    checks++;
    if (m_done !== 3'b100) begin
      errors++;
      $display("FAIL wresp_done: got %b expected 100", m_done);
    end
    $display("txn write done: m_done=%b", m_done);
    tick();
    s_bvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Master 0 has been waiting through the write; one idle cycle precedes its grant.
    checks++;
    if (s_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got s_req=%b expected 0", s_req);
    end
    tick();
    checks++;
    if (s_req !== 1'b1 || s_we !== 1'b0) begin
      errors++;
      $display("FAIL b2b_grant: got s_req=%b we=%b expected 1 0", s_req, s_we);
    end
    addr_phase("b2b", 32'h0000_3000, 3'b001);
    m_req = 3'b000;
    read_burst("b2b", 0, 1);
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_err: got %b expected 0", proto_err);
    end
  endtask

  task automatic test_proto_err();
    set_master(0, 1'b0, 32'h0000_4000, 4'd3);
    m_req = 3'b001;
    addr_phase("short", 32'h0000_4000, 3'b001);
    m_req = 3'b000;
    read_burst("short", 0, 3);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL short_err: got %b expected 1", proto_err);
    end
    set_master(0, 1'b0, 32'h0000_5000, 4'd0);
    m_req = 3'b001;
    addr_phase("after_err", 32'h0000_5000, 3'b001);
    m_req = 3'b000;
    read_burst("after_err", 0, 1);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", proto_err);
    end
  endtask

  task automatic test_async_reset();
    set_master(1, 1'b0, 32'h0000_6000, 4'd2);
    m_req = 3'b010;
    addr_phase("arst", 32'h0000_6000, 3'b010);
    m_req = 3'b000;
    s_rvalid = 1'b1;
    s_rlast  = 1'b1;
    s_rdata  = 32'h1234_5678;
    #1;
    checks++;
    if (m_rvalid !== 3'b010) begin
      errors++;
      $display("FAIL arst_pre: got rvalid=%b expected 010", m_rvalid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (m_rvalid !== 3'b000 || m_rdata !== 32'h0 || m_rlast !== 1'b0 || m_done !== 3'b000 ||
        s_req !== 1'b0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL arst_outputs: got rvalid=%b rdata=%h rlast=%b done=%b s_req=%b err=%b expected all 0",
               m_rvalid, m_rdata, m_rlast, m_done, s_req, proto_err);
    end
    $display("txn async reset: rvalid=%b proto_err=%b", m_rvalid, proto_err);
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    // rr_ptr was 1 before reset; a cleared pointer must pick master 0 first.
    set_master(0, 1'b0, 32'h0000_7000, 4'd0);
    set_master(1, 1'b0, 32'h0000_8000, 4'd0);
    m_req = 3'b011;
    addr_phase("post_rst", 32'h0000_7000, 3'b001);
    m_req = 3'b000;
    read_burst("post_rst", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    m_req = '0; m_we = '0; m_wvalid = '0;
    m_addr = '0; m_wdata = '0; m_len = '0;
    s_ack = 1'b0; s_wready = 1'b0; s_rdata = '0;
    s_rvalid = 1'b0; s_rlast = 1'b0; s_bvalid = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_priority_write();
    test_back_to_back();
    test_proto_err();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
